// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C request arbiter and the I2C master.
//   arb_state_t   : arbiter sequencing states
//   mst_state_t   : bit-level master states, kept here so both blocks share one package
//   I2C_ADDR_W    : 7-bit slave address width
//   I2C_DATA_W    : byte width
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [2:0] {
        MST_IDLE,
        MST_START,
        MST_ADDR,
        MST_WRDATA,
        MST_RDDATA,
        MST_ACK,
        MST_STOP
    } mst_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// The search starts one position above ptr_i and wraps at NUM_REQ, so the
// requester named by ptr_i (the previous winner) has the lowest priority.
//   req_i   : request vector
//   ptr_i   : index of the previous winner
//   gnt_o   : one-hot winner (all zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request is present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    always_comb begin
        logic found;
        int   pos;
        found   = 1'b0;
        pos     = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                valid_o    = 1'b1;
                idx_o      = IDX_W'(pos);
                gnt_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between NUM_REQ requesters.
// Round-robin grant, latches the winner's request fields, sequences the
// master's en/busy/done handshake, returns the result to the winner and
// aborts any transaction that exceeds TIMEOUT_CYC cycles.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   req_i/rw_i/addr_i/wdata_i     : per-requester request (packed, requester 0 in LSBs)
//   gnt_o, done_o                 : one-hot grant and one-cycle completion pulse
//   nack_o, rdata_o, timeout_o    : response status/data, valid with done_o
//   m_en_o/m_rw_o/m_addr_o/m_data_o : request towards the master
//   m_busy_i/m_done_i/m_ack_i/m_data_i : status from the master
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            rw_i,
    input  logic [NUM_REQ*I2C_ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*I2C_DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          nack_o,
    output logic [I2C_DATA_W-1:0]         rdata_o,
    output logic                          timeout_o,
    output logic                          m_en_o,
    output logic                          m_rw_o,
    output logic [I2C_ADDR_W-1:0]         m_addr_o,
    output logic [I2C_DATA_W-1:0]         m_data_o,
    input  logic                          m_busy_i,
    input  logic                          m_done_i,
    input  logic                          m_ack_i,
    input  logic [I2C_DATA_W-1:0]         m_data_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    // Unpacked views of the packed per-requester fields.
    logic [I2C_ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [I2C_DATA_W-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*I2C_ADDR_W +: I2C_ADDR_W];
            assign wdata_arr[gi] = wdata_i[gi*I2C_DATA_W +: I2C_DATA_W];
        end
    endgenerate

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  rw_q, rw_d;
    logic [I2C_ADDR_W-1:0] addr_q, addr_d;
    logic [I2C_DATA_W-1:0] data_q, data_d;
    logic                  nack_q, nack_d;
    logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
    logic                  timeout_q, timeout_d;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic                  wd_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        nack_d    = nack_q;
        rdata_d   = rdata_q;
        timeout_d = 1'b0;   // high only for the RESP cycle of an aborted transaction

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    rw_d    = rw_i[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    data_d  = wdata_arr[pick_idx];
                    wd_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A done on the expiry cycle is a real completion, so it is
                // checked before the watchdog.
                if (m_done_i) begin
                    nack_d  = ~m_ack_i;
                    rdata_d = m_data_i;
                    state_d = RESP;
                end else if (wd_expired) begin
                    nack_d    = 1'b1;
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (state_q == ISSUE && m_busy_i) begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                ptr_d   = idx_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= PTR_RST;
            wd_q      <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            nack_q    <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            nack_q    <= nack_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    // Enable is withdrawn on the expiry cycle so the master never sees a
    // fresh start while the arbiter is aborting.
    assign m_en_o    = (state_q == ISSUE) && !wd_expired;
    assign gnt_o     = gnt_q;
    assign done_o    = (state_q == RESP) ? gnt_q : '0;
    assign nack_o    = nack_q;
    assign rdata_o   = rdata_q;
    assign timeout_o = timeout_q;
    assign m_rw_o    = rw_q;
    assign m_addr_o  = addr_q;
    assign m_data_o  = data_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench: the driver plans each transaction, predicts the winner
// and response from round-robin and watchdog rules, and queues expectations;
// a monitor checks issue and completion events; a master model responds.
module tb_i2c_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [N-1:0]     req_i, rw_i;
    logic [N*7-1:0]   addr_i;
    logic [N*8-1:0]   wdata_i;
    logic [N-1:0]     gnt_o, done_o;
    logic             nack_o, timeout_o, m_en_o, m_rw_o;
    logic [7:0]       rdata_o, m_data_o, m_data_i;
    logic [6:0]       m_addr_o;
    logic             m_busy_i, m_done_i, m_ack_i;

    always #5 clk_i = ~clk_i;

    i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .rw_i(rw_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o),
        .nack_o(nack_o), .rdata_o(rdata_o), .timeout_o(timeout_o),
        .m_en_o(m_en_o), .m_rw_o(m_rw_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
        .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_ack_i(m_ack_i), .m_data_i(m_data_i)
    );

    typedef struct {
        int       idx;
        bit       rw;
        bit [6:0] addr;
        bit [7:0] wdata;
        bit       nack;
        bit [7:0] rdata;
        bit       tmo;
        int       lat;
    } exp_t;

    typedef struct {
        int       busy_at;
        int       done_at;
        bit       ack;
        bit [7:0] data;
    } beh_t;

    exp_t exp_q[$];
    beh_t beh_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // ---------------- requester model ----------------
    bit       pend [N];
    bit       rwf  [N];
    bit [6:0] adf  [N];
    bit [7:0] wdf  [N];
    int       mptr = N - 1;

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_i[i]          = pend[i];
            rw_i[i]           = rwf[i];
            addr_i[i*7 +: 7]  = adf[i];
            wdata_i[i*8 +: 8] = wdf[i];
        end
    endtask

    task automatic add_req(input int i, input bit rw, input bit [6:0] a, input bit [7:0] d);
        pend[i] = 1'b1; rwf[i] = rw; adf[i] = a; wdf[i] = d;
    endtask

    task automatic add_rand(input int i);
        add_req(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++)
            if (pend[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    function automatic beh_t mk_beh(input int b, input int d, input bit ack, input bit [7:0] data);
        beh_t r;
        r.busy_at = b; r.done_at = d; r.ack = ack; r.data = data;
        return r;
    endfunction

    function automatic beh_t rand_beh();
        int sel, b;
        sel = int'($urandom_range(0, 9));
        b   = int'($urandom_range(0, 3));
        case (sel)
            0: return mk_beh(b, 1000, 1'b1, 8'($urandom));           // hang -> timeout
            1: return mk_beh(b, TO - 1, 1'($urandom_range(0, 1)), 8'($urandom)); // done on expiry
            2: return mk_beh(5, 0, 1'b1, 8'($urandom));              // done while still in ISSUE
            3: return mk_beh(1000, 1000, 1'b1, 8'h00);               // never busy, never done
            default: return mk_beh(b, int'($urandom_range(b, 14)),
                                   ($urandom_range(0, 3) != 0), 8'($urandom));
        endcase
    endfunction

    exp_t last_exp;

    task automatic push_expect(input beh_t b, output int w);
        exp_t e;
        if (rr_pick() < 0) add_rand(int'($urandom_range(0, N - 1)));
        drive_reqs();
        w       = rr_pick();
        e.idx   = w;
        e.rw    = rwf[w];
        e.addr  = adf[w];
        e.wdata = wdf[w];
        if (b.done_at <= TO - 1) begin
            e.nack = !b.ack; e.rdata = b.data; e.tmo = 1'b0; e.lat = b.done_at + 1;
        end else begin
            e.nack = 1'b1; e.rdata = 8'h00; e.tmo = 1'b1; e.lat = TO;
        end
        exp_q.push_back(e);
        beh_q.push_back(b);
        last_exp = e;
    endtask

    // Called on a negedge; returns on the negedge of the response cycle.
    task automatic run_txn(input beh_t b);
        int  w;
        bit  got;
        push_expect(b, w);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (done_o != '0) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("done_within_budget", 32'(got), 32'd1);
            finish_run();
        end
        $display("txn: req %0d rw=%0d addr=0x%02h nack=%0d rdata=0x%02h tmo=%0d",
                 w, last_exp.rw, last_exp.addr, last_exp.nack, last_exp.rdata, last_exp.tmo);
        pend[w] = 1'b0;
        mptr    = w;
        drive_reqs();
    endtask

    // ---------------- master model ----------------
    bit   m_act = 1'b0;
    int   m_k;
    beh_t m_b;

    initial begin
        m_busy_i = 1'b0; m_done_i = 1'b0; m_ack_i = 1'b0; m_data_i = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                m_act = 1'b0; m_busy_i = 1'b0; m_done_i = 1'b0; m_data_i = 8'h00;
            end else begin
                if (!m_act && m_en_o) begin
                    if (beh_q.size() == 0) begin
                        check("master_behaviour_available", 32'(beh_q.size()), 32'd1);
                    end else begin
                        m_b = beh_q.pop_front(); m_act = 1'b1; m_k = 0;
                    end
                end else if (m_act && done_o != '0) begin
                    m_act = 1'b0; m_busy_i = 1'b0; m_done_i = 1'b0; m_data_i = 8'h00;
                end
                if (m_act) begin
                    m_busy_i = (m_k >= m_b.busy_at) && (m_k < m_b.done_at);
                    m_done_i = (m_k == m_b.done_at);
                    m_ack_i  = m_b.ack;
                    m_data_i = (m_k == m_b.done_at) ? m_b.data : 8'h00;
                    m_k++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int       cyc = 0, start_cyc = 0, last_done_cyc = -1;
    bit       prev_en = 1'b0, hold_chk = 1'b0;
    bit [7:0] hold_rdata;
    exp_t     me;

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                prev_en = 1'b0; hold_chk = 1'b0;
            end else begin
                if (m_en_o && !prev_en) begin
                    start_cyc = cyc;
                    if (last_done_cyc >= 0) check("idle_gap", 32'(cyc - last_done_cyc), 32'd2);
                    if (exp_q.size() == 0) begin
                        check("issue_has_expectation", 32'(exp_q.size()), 32'd1);
                    end else begin
                        me = exp_q[0];
                        check("issue_gnt",   32'(gnt_o),    32'd1 << me.idx);
                        check("issue_addr",  32'(m_addr_o), 32'(me.addr));
                        check("issue_wdata", 32'(m_data_o), 32'(me.wdata));
                        check("issue_rw",    32'(m_rw_o),   32'(me.rw));
                    end
                end
                prev_en = m_en_o;
                if (done_o != '0) begin
                    if (exp_q.size() == 0) begin
                        check("done_has_expectation", 32'(exp_q.size()), 32'd1);
                    end else begin
                        me = exp_q.pop_front();
                        check("done_onehot",  32'(done_o),    32'd1 << me.idx);
                        check("resp_gnt",     32'(gnt_o),     32'd1 << me.idx);
                        check("resp_nack",    32'(nack_o),    32'(me.nack));
                        check("resp_rdata",   32'(rdata_o),   32'(me.rdata));
                        check("resp_timeout", 32'(timeout_o), 32'(me.tmo));
                        check("resp_latency", 32'(cyc - start_cyc), 32'(me.lat));
                        check("resp_en_low",  32'(m_en_o),    32'd0);
                        hold_rdata = me.rdata;
                    end
                    last_done_cyc = cyc;
                    hold_chk      = 1'b1;
                end else if (hold_chk) begin
                    check("rdata_held", 32'(rdata_o), 32'(hold_rdata));
                    check("done_single_cycle", 32'(done_o), 32'd0);
                    hold_chk = 1'b0;
                end
                if (timeout_o && done_o == '0) check("timeout_only_with_done", 32'(timeout_o), 32'd0);
            end
        end
    end

    function automatic logic [31:0] all_out_or();
        return 32'(|{gnt_o, done_o, nack_o, rdata_o, timeout_o, m_en_o, m_rw_o, m_addr_o, m_data_o});
    endfunction

    // ---------------- driver ----------------
    initial begin
        bit got;
        int w;
        rst_ni = 1'b0;
        req_i = '0; rw_i = '0; addr_i = '0; wdata_i = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; rwf[i] = 0; adf[i] = 0; wdf[i] = 0; end
        repeat (3) @(negedge clk_i);
        check("reset_outputs_zero", all_out_or(), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // single write from requester 0
        add_req(0, 1'b0, 7'h50, 8'hA5);
        run_txn(mk_beh(2, 10, 1'b1, 8'h00));
        // read from requester 2
        add_req(2, 1'b1, 7'h1D, 8'h00);
        run_txn(mk_beh(1, 8, 1'b1, 8'h3C));
        // all four requesting: round-robin order
        for (int i = 0; i < N; i++) add_rand(i);
        for (int t = 0; t < N; t++) run_txn(mk_beh(1, 5 + t, 1'b1, 8'($urandom)));
        // NACK followed by a normal grant
        add_req(1, 1'b0, 7'h22, 8'h5A);
        add_req(3, 1'b1, 7'h33, 8'h00);
        run_txn(mk_beh(1, 6, 1'b0, 8'h77));
        run_txn(mk_beh(1, 4, 1'b1, 8'h81));
        // watchdog: hung master, then done exactly on the expiry cycle
        add_req(0, 1'b1, 7'h44, 8'h00);
        run_txn(mk_beh(1, 1000, 1'b1, 8'hEE));
        add_req(1, 1'b1, 7'h45, 8'h00);
        run_txn(mk_beh(1, TO - 1, 1'b1, 8'h96));

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) add_rand(i);
            run_txn(rand_beh());
        end

        // reset in the middle of WAIT
        add_req(3, 1'b1, 7'h2A, 8'h11);
        push_expect(mk_beh(1, 1000, 1'b1, 8'h00), w);
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (m_busy_i) begin got = 1'b1; break; end
        end
        check("busy_before_reset", 32'(got), 32'd1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs_zero", all_out_or(), 32'd0);
        exp_q.delete();
        beh_q.delete();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        mptr = N - 1;
        last_done_cyc = -1;
        repeat (2) @(negedge clk_i);
        check("reset_held_outputs_zero", all_out_or(), 32'd0);
        add_req(1, 1'b0, 7'h61, 8'hC3);
        add_req(2, 1'b1, 7'h62, 8'h00);
        drive_reqs();
        rst_ni = 1'b1;
        run_txn(mk_beh(0, 3, 1'b1, 8'h19));
        run_txn(mk_beh(2, 7, 1'b1, 8'h2B));

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        finish_run();
    end

endmodule
